// File: rtl/mem_lsu.sv
// RV32I load/store unit: validates one request at a time, drives the main_mem
// data port with lane-formatted strobes and returns extended load data.
module mem_lsu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic        o_dm_ren,
    output logic        o_dm_wen,
    output logic [3:0]  o_dm_ben,
    output logic [13:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    input  logic [31:0] i_dm_rdata,
    input  logic        i_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDATA, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_req_bad;
    logic        w_unused_addr;

    function automatic logic f_illegal(input logic st, input logic [2:0] f3,
                                       input logic [1:0] lane);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lane[0];
            3'b010:  bad = |lane;
            3'b100:  bad = st;
            3'b101:  bad = st | lane[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] f_store_ben(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] ben;
        case (size)
            2'b00:   ben = 4'b0001 << lane;
            2'b01:   ben = lane[1] ? 4'b1100 : 4'b0011;
            default: ben = 4'b1111;
        endcase
        return ben;
    endfunction

    function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] f_load_fmt(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // Upper address bits alias onto the 64 KiB window.
    assign w_unused_addr = ^i_addr[31:16];

    assign w_accept  = (r_state == S_IDLE) && i_valid;
    assign w_req_bad = f_illegal(i_store, i_funct3, i_addr[1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 16'h0;
            r_wdata  <= 32'h0;
            r_fault  <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_store  <= i_store;
                r_funct3 <= i_funct3;
                r_addr   <= i_addr[15:0];
                r_wdata  <= i_wdata;
                r_fault  <= w_req_bad;
            end
            if (r_state == S_RDATA)
                r_rdata <= f_load_fmt(r_funct3, r_addr[1:0], i_dm_rdata);
        end
    end

    // Memory strobes exist only in an ISSUE cycle that sees i_ready.
    always_comb begin
        w_state_nxt = r_state;
        o_dm_ren    = 1'b0;
        o_dm_wen    = 1'b0;
        o_dm_ben    = 4'b0000;
        o_dm_wdata  = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (i_valid)
                    w_state_nxt = w_req_bad ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (i_ready) begin
                    w_state_nxt = r_store ? S_DONE : S_RDATA;
                    o_dm_ren    = ~r_store;
                    o_dm_wen    = r_store;
                    if (r_store) begin
                        o_dm_ben   = f_store_ben(r_funct3[1:0], r_addr[1:0]);
                        o_dm_wdata = f_store_data(r_funct3[1:0], r_wdata);
                    end
                end
            end
            S_RDATA: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_fault   = (r_state == S_DONE) && r_fault;
    assign o_rdata   = r_rdata;
    assign o_dm_addr = r_addr[15:2];

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: acts as the main_mem responder and checks every request
// against a byte-addressed model of the RV32I load/store rules.
module tb_mem_lsu;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_fault;
    logic [31:0] o_rdata;
    logic        o_dm_ren;
    logic        o_dm_wen;
    logic [3:0]  o_dm_ben;
    logic [13:0] o_dm_addr;
    logic [31:0] o_dm_wdata;
    logic [31:0] i_dm_rdata;
    logic        i_ready;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rdata;

    logic [31:0] resp_mem [0:16383] = '{default: 32'h0};
    logic [7:0]  mbyte    [0:65535] = '{default: 8'h00};

    mem_lsu dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_store    (i_store),
        .i_funct3   (i_funct3),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_fault    (o_fault),
        .o_rdata    (o_rdata),
        .o_dm_ren   (o_dm_ren),
        .o_dm_wen   (o_dm_wen),
        .o_dm_ben   (o_dm_ben),
        .o_dm_addr  (o_dm_addr),
        .o_dm_wdata (o_dm_wdata),
        .i_dm_rdata (i_dm_rdata),
        .i_ready    (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Responder: writes honour byte enables, read data appears one cycle later,
    // and the data bus carries noise whenever no read was issued.
    always @(posedge i_clk) begin
        if (o_dm_wen)
            for (int l = 0; l < 4; l++)
                if (o_dm_ben[l]) resp_mem[o_dm_addr][8*l +: 8] <= o_dm_wdata[8*l +: 8];
        if (o_dm_ren) i_dm_rdata <= resp_mem[o_dm_addr];
        else          i_dm_rdata <= $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        check({pfx, "_ctl"}, {27'h0, o_busy, o_done, o_fault, o_dm_ren, o_dm_wen}, 32'h0);
        check({pfx, "_ben"}, {28'h0, o_dm_ben}, 32'h0);
        check({pfx, "_wdata"}, o_dm_wdata, 32'h0);
        check({pfx, "_addr"}, {18'h0, o_dm_addr}, 32'h0);
        check({pfx, "_rdata"}, o_rdata, 32'h0);
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int stall, input bit dup);
        int          nb, sc, scnt, dc, bad_idle, exp_dc;
        logic        legal;
        logic [3:0]  eben;
        logic [31:0] ewd, eload;
        logic [15:0] ba;
        ba = a[15:0];
        nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if ((int'(ba) % nb) != 0) legal = 1'b0;
        eben = st ? 4'(((1 << nb) - 1) << ba[1:0]) : 4'h0;
        ewd = 32'h0;
        if (st)
            for (int l = 0; l < 4; l++) ewd[8*l +: 8] = wd[8*(l % nb) +: 8];
        eload = 32'h0;
        for (int i = 0; i < nb; i++) eload[8*i +: 8] = mbyte[16'(ba + 16'(i))];
        if (!f3[2] && nb == 1) eload = {{24{eload[7]}}, eload[7:0]};
        if (!f3[2] && nb == 2) eload = {{16{eload[15]}}, eload[15:0]};
        exp_dc = !legal ? 1 : (st ? stall + 2 : stall + 3);

        @(negedge i_clk);
        i_valid = 1'b1; i_store = st; i_funct3 = f3; i_addr = a; i_wdata = wd;
        i_ready = (stall == 0);
        @(posedge i_clk);
        sc = -1; scnt = 0; dc = -1; bad_idle = 0;
        for (int c = 1; c <= stall + 10; c++) begin
            @(negedge i_clk);
            if (dup && c == 2) begin
                i_valid = 1'b1; i_store = ~st; i_addr = a ^ 32'h4; i_wdata = ~wd;
            end else begin
                i_valid = 1'b0;
            end
            i_ready = (c <= stall) ? 1'b0 : (c == stall + 1) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (o_dm_ren || o_dm_wen) begin
                scnt++;
                if (sc < 0) begin
                    sc = c;
                    check("ren", {31'h0, o_dm_ren}, {31'h0, ~st});
                    check("wen", {31'h0, o_dm_wen}, {31'h0, st});
                    check("ben", {28'h0, o_dm_ben}, {28'h0, eben});
                    check("wdata", o_dm_wdata, ewd);
                    check("addr", {18'h0, o_dm_addr}, {18'h0, ba[15:2]});
                end
            end else if (o_dm_ben != 4'h0 || o_dm_wdata != 32'h0) begin
                bad_idle++;
            end
            if (o_done) begin
                dc = c;
                if (legal && !st) exp_rdata = eload;
                check("fault", {31'h0, o_fault}, {31'h0, ~legal});
                check("rdata", o_rdata, exp_rdata);
                break;
            end
        end
        i_valid = 1'b0;
        if (legal && st)
            for (int i = 0; i < nb; i++) mbyte[16'(ba + 16'(i))] = wd[8*i +: 8];
        check("done_cycle", 32'(dc), 32'(exp_dc));
        check("strobe_count", 32'(scnt), legal ? 32'd1 : 32'd0);
        if (legal) check("strobe_cycle", 32'(sc), 32'(stall + 1));
        check("idle_lanes", 32'(bad_idle), 32'd0);
        @(negedge i_clk);
        #1;
        check("idle_after", {31'h0, o_busy}, 32'h0);
    endtask

    initial begin
        int nd;
        logic [2:0] ld_f3 [0:4];
        logic       st;
        logic [2:0] f3;
        ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
        i_rst = 1'b1; i_valid = 1'b0; i_store = 1'b0; i_funct3 = 3'd0;
        i_addr = 32'h0; i_wdata = 32'h0; i_ready = 1'b1;
        exp_rdata = 32'h0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk_zero("reset");

        run_req(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b0);
        run_req(1'b0, 3'd2, 32'h0000_0100, 32'h0, 0, 1'b0);
        run_req(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 0, 1'b0);
        run_req(1'b0, 3'd0, 32'h0000_1003, 32'h0, 0, 1'b0);
        run_req(1'b0, 3'd4, 32'h0000_1003, 32'h0, 0, 1'b0);
        run_req(1'b1, 3'd1, 32'h0000_2002, 32'h0000_8001, 0, 1'b0);
        run_req(1'b0, 3'd1, 32'h0000_2002, 32'h0, 0, 1'b0);
        run_req(1'b0, 3'd5, 32'h0000_2002, 32'h0, 0, 1'b0);
        run_req(1'b0, 3'd1, 32'h0000_1001, 32'h0, 0, 1'b0);
        run_req(1'b0, 3'd2, 32'h0000_1002, 32'h0, 0, 1'b0);
        run_req(1'b0, 3'd3, 32'h0000_0100, 32'h0, 0, 1'b0);
        run_req(1'b1, 3'd4, 32'h0000_0100, 32'h1234_5678, 0, 1'b0);
        run_req(1'b0, 3'd2, 32'hABCD_0100, 32'h0, 5, 1'b1);

        // Reset while a load is stalled in ISSUE.
        @(negedge i_clk);
        i_valid = 1'b1; i_store = 1'b0; i_funct3 = 3'd2; i_addr = 32'h0000_0100; i_ready = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        check("rst_issue_busy", {31'h0, o_busy}, 32'h1);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0; i_ready = 1'b1;
        #1;
        exp_rdata = 32'h0;
        chk_zero("rst_issue");

        // Reset while a load is in RDATA.
        @(negedge i_clk);
        i_valid = 1'b1; i_store = 1'b0; i_funct3 = 3'd2; i_addr = 32'h0000_0100; i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        check("rst_rdata_ren", {31'h0, o_dm_ren}, 32'h1);
        @(negedge i_clk);
        #1;
        check("rst_rdata_state", {30'h0, o_busy, o_done}, 32'h2);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk_zero("rst_rdata");
        nd = 0;
        repeat (3) begin
            @(negedge i_clk);
            #1;
            if (o_done) nd++;
        end
        check("rst_no_done", 32'(nd), 32'd0);
        run_req(1'b0, 3'd2, 32'h0000_0100, 32'h0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom_range(0, 7));
            run_req(st, f3, {16'($urandom), 16'h3000 + 16'($urandom_range(0, 15))},
                    $urandom, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
